// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the oversampling UART receiver.
//   - uart_rx_state_e : receiver FSM state (IDLE / BUSY)
//   - START_OFFSET    : baud counter preload at start detect (mid start bit)
//   - OVERSAMPLE      : x16 ticks per bit
//   - FRAME_BITS_*    : samples per frame incl. start and stop bits
//   - frame_bits()    : bit counter preload for a given parity setting
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } uart_rx_state_e;

  localparam int unsigned START_OFFSET     = 8;
  localparam int unsigned OVERSAMPLE       = 16;
  localparam int unsigned FRAME_BITS_NOPAR = 10;
  localparam int unsigned FRAME_BITS_PAR   = 11;

  localparam int unsigned BAUD_CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_CNT_W  = 4;

  function automatic logic [BIT_CNT_W-1:0] frame_bits(input logic par_en);
    return par_en ? BIT_CNT_W'(FRAME_BITS_PAR) : BIT_CNT_W'(FRAME_BITS_NOPAR);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the serial line. Both flops reset to 1 so the
// line reads as idle while the chain fills after reset.
// Ports:
//   clk_i  - core clock
//   rst_i  - synchronous active-high reset
//   d      - asynchronous serial input
//   q      - synchronized output (2 clk_i cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Oversampling UART receive engine for 8N1 / 8E1 / 8O1 frames, LSB first.
// A start bit (rx low while enabled) arms a 16x baud counter preloaded so the
// first sample lands mid start bit; each later sample is one bit period on.
//
// Build option: UART_RX_INPUT_SYNC_EN
//   defined   - rx goes through a 2-flop synchronizer (adds 2 cycles latency)
//   undefined - rx is used directly and must already be synchronous to clk_i
//
// Ports:
//   clk_i          in   core clock, rising edge
//   rst_i          in   synchronous reset, active high
//   rx_enable      in   receiver enable; low aborts any frame
//   tick_baud_x16  in   single-cycle strobe at 16x baud
//   parity_enable  in   frame carries a parity bit after the data
//   parity_odd     in   1 = odd parity, 0 = even
//   rx             in   serial line, idles high
//   tick_baud      out  pulse at every mid-bit sample point while BUSY
//   rx_valid       out  one-cycle pulse, frame complete (no back-pressure:
//                       the consumer must take rx_data in that cycle or
//                       before the next frame completes)
//   rx_data        out  last received byte, held until the next frame
//   idle           out  1 when no frame is in progress
//   frame_err      out  pulse with rx_valid when the stop bit sampled 0
//   rx_parity_err  out  pulse with rx_valid on parity mismatch
//   state_dbg      out  current FSM state for observation
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_enable,
  input  logic                 tick_baud_x16,
  input  logic                 parity_enable,
  input  logic                 parity_odd,
  input  logic                 rx,
  output logic                 tick_baud,
  output logic                 rx_valid,
  output logic [DataWidth-1:0] rx_data,
  output logic                 idle,
  output logic                 frame_err,
  output logic                 rx_parity_err,
  output uart_rx_state_e       state_dbg
);

  // ---------------------------------------------------------------------------
  // Serial input conditioning
  // ---------------------------------------------------------------------------
  logic rx_s;

`ifdef UART_RX_INPUT_SYNC_EN
  uart_rx_sync u_rx_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (rx),
    .q     (rx_s)
  );
`else
  assign rx_s = rx;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  uart_rx_state_e        state_q;
  uart_rx_state_e        state_d;
  logic [BAUD_CNT_W-1:0] baud_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  // Holds the most recent DataWidth+1 samples. At the stop sample it holds
  // {parity, data} for parity frames and {data, start} otherwise, so the
  // stop bit itself never needs to be stored.
  logic [DataWidth:0]    shift_q;
  // Parity setting captured at start detect so the frame length and the
  // data extraction agree even if the CSR changes mid-frame.
  logic                  par_en_q;

  logic                  start_det;
  logic                  sample;
  logic                  first_sample;
  logic                  glitch;
  logic                  done;
  logic                  abort;

  logic [DataWidth-1:0]  data_par;
  logic [DataWidth-1:0]  data_nopar;
  logic                  par_bit;
  logic [DataWidth-1:0]  frame_data;

  assign data_par   = shift_q[DataWidth-1:0];
  assign par_bit    = shift_q[DataWidth];
  assign data_nopar = shift_q[DataWidth:1];
  assign frame_data = par_en_q ? data_par : data_nopar;

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    start_det    = 1'b0;
    glitch       = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    sample       = (state_q == BUSY) && tick_baud_x16 &&
                   (baud_cnt_q == BAUD_CNT_W'(OVERSAMPLE - 1));
    first_sample = (bit_cnt_q == frame_bits(par_en_q));

    case (state_q)
      IDLE: begin
        if (rx_enable && !rx_s) begin
          start_det = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!rx_enable) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sample) begin
          if (first_sample && rx_s) begin
            // Start bit was high at its centre: line glitch, not a frame.
            glitch  = 1'b1;
            state_d = IDLE;
          end else if (bit_cnt_q == BIT_CNT_W'(1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, shift register and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '1;
      par_en_q      <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      frame_err     <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_valid      <= done;
      frame_err     <= done & ~rx_s;
      rx_parity_err <= done & par_en_q & (^{parity_odd, data_par, par_bit});
      if (done) begin
        rx_data <= frame_data;
      end

      if (start_det) begin
        baud_cnt_q <= BAUD_CNT_W'(START_OFFSET);
        bit_cnt_q  <= frame_bits(parity_enable);
        par_en_q   <= parity_enable;
      end else if ((state_q == BUSY) && tick_baud_x16) begin
        // Natural wrap of the counter width gives modulo-OVERSAMPLE.
        baud_cnt_q <= baud_cnt_q + BAUD_CNT_W'(1);
      end

      if (sample) begin
        shift_q   <= {rx_s, shift_q[DataWidth:1]};
        bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
      end
    end
  end

  assign tick_baud = sample;
  assign idle      = (state_q == IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core with tick_baud_x16 tied high, so one bit
// period is 16 clk_i cycles. Cycle t is the cycle whose inputs carry the
// first low level of the start bit; a frame of n samples then shows
// tick_baud at t+8+16k and rx_valid at t+8+16(n-1)+1.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;
  import uart_rx_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic           clk_i         = 1'b0;
  logic           rst_i         = 1'b1;
  logic           rx_enable     = 1'b0;
  logic           tick_baud_x16 = 1'b1;
  logic           parity_enable = 1'b0;
  logic           parity_odd    = 1'b0;
  logic           rx            = 1'b1;
  logic           tick_baud;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           idle;
  logic           frame_err;
  logic           rx_parity_err;
  uart_rx_state_e state_dbg;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  uart_rx_core #(.DataWidth(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_enable     (rx_enable),
    .tick_baud_x16 (tick_baud_x16),
    .parity_enable (parity_enable),
    .parity_odd    (parity_odd),
    .rx            (rx),
    .tick_baud     (tick_baud),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .idle          (idle),
    .frame_err     (frame_err),
    .rx_parity_err (rx_parity_err),
    .state_dbg     (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Monitor: event queues sampled on the falling edge
  // ---------------------------------------------------------------------------
  int          tick_q[$];
  int          valid_q[$];
  int          rise_q[$];
  int          fall_q[$];
  logic [7:0]  data_q[$];
  logic        fe_q[$];
  logic        pe_q[$];
  logic        idle_prev = 1'b1;
  logic [31:0] exp_q[$];

  always @(negedge clk_i) begin
    if (tick_baud) tick_q.push_back(cyc);
    if (rx_valid) begin
      valid_q.push_back(cyc);
      data_q.push_back(rx_data);
      fe_q.push_back(frame_err);
      pe_q.push_back(rx_parity_err);
    end
    if (idle && !idle_prev) rise_q.push_back(cyc);
    if (!idle && idle_prev) fall_q.push_back(cyc);
    idle_prev = idle;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    tick_q.delete();
    valid_q.delete();
    rise_q.delete();
    fall_q.delete();
    data_q.delete();
    fe_q.delete();
    pe_q.delete();
  endtask

  // Checks one complete frame: sample points, completion cycle, payload,
  // flags and the idle edges around it.
  task automatic check_frame(input string tag, input int t0, input int nbits,
                             input int nticks, input logic [7:0] data,
                             input logic fe, input logic pe);
    int last;
    last = t0 + 8 + 16 * (nbits - 1);
    exp_q.delete();
    for (int k = 0; k < nbits; k++) exp_q.push_back(32'(t0 + 8 + 16 * k));
    check({tag, ".tick_count"}, tick_q.size(), nticks);
    for (int k = 0; k < nbits; k++)
      check({tag, ".tick_at"}, (k < tick_q.size()) ? tick_q[k] : -1, exp_q[k]);
    check({tag, ".valid_count"}, valid_q.size(), 1);
    check({tag, ".valid_at"}, (valid_q.size() > 0) ? valid_q[0] : -1, last + 1);
    check({tag, ".data"}, (data_q.size() > 0) ? {24'h0, data_q[0]} : 32'hdead, {24'h0, data});
    check({tag, ".frame_err"}, (fe_q.size() > 0) ? {31'h0, fe_q[0]} : 32'hdead, {31'h0, fe});
    check({tag, ".parity_err"}, (pe_q.size() > 0) ? {31'h0, pe_q[0]} : 32'hdead, {31'h0, pe});
    check({tag, ".idle_fall"}, (fall_q.size() > 0) ? fall_q[0] : -1, t0 + 1);
    check({tag, ".idle_rise"}, (rise_q.size() > 0) ? rise_q[0] : -1, last + 1);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_on,
                            input logic par_bit, input logic stop_bit,
                            output int t0);
    step();
    clear_mon();
    rx = 1'b0;
    t0 = cyc;
    repeat (16) step();
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (16) step();
    end
    if (par_on) begin
      rx = par_bit;
      repeat (16) step();
    end
    rx = stop_bit;
    repeat (16) step();
    rx = 1'b1;
    repeat (24) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".idle"}, {31'h0, idle}, 32'h1);
    check({tag, ".rx_valid"}, {31'h0, rx_valid}, 32'h0);
    check({tag, ".rx_data"}, {24'h0, rx_data}, 32'h0);
    check({tag, ".frame_err"}, {31'h0, frame_err}, 32'h0);
    check({tag, ".parity_err"}, {31'h0, rx_parity_err}, 32'h0);
    check({tag, ".tick_baud"}, {31'h0, tick_baud}, 32'h0);
    check({tag, ".state"}, {31'h0, state_dbg}, {31'h0, IDLE});
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int a;

    // Reset
    rst_i = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_i     = 1'b0;
    rx_enable = 1'b1;
    repeat (4) step();

    // 0x55, 8N1
    parity_enable = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, t0);
    check_frame("n1_55", t0, 10, 10, 8'h55, 1'b0, 1'b0);

    // 0xA3, 8E1: popcount 4, so the correct even parity bit is 0
    parity_enable = 1'b1;
    parity_odd    = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, t0);
    check_frame("e1_a3_ok", t0, 11, 11, 8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, t0);
    check_frame("e1_a3_bad", t0, 11, 11, 8'hA3, 1'b0, 1'b1);

    // 0xA3, 8O1: parity bit 1 is correct for odd parity
    parity_odd = 1'b1;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, t0);
    check_frame("o1_a3_ok", t0, 11, 11, 8'hA3, 1'b0, 1'b0);
    parity_odd = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, t0);
    check_frame("o1_a3_as_even", t0, 11, 11, 8'hA3, 1'b0, 1'b1);

    // 0x3C with stop bit 0. The still-low line restarts the receiver in the
    // rx_valid cycle; that second start samples high and is dropped, adding
    // one extra tick_baud at t+161.
    parity_enable = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, t0);
    check_frame("stop0_3c", t0, 10, 11, 8'h3C, 1'b1, 1'b0);
    check("stop0_3c.restart_tick", (tick_q.size() > 10) ? tick_q[10] : -1, t0 + 161);
    check("stop0_3c.restart_fall", (fall_q.size() > 1) ? fall_q[1] : -1, t0 + 154);

    // Glitch: 4 low cycles
    step();
    clear_mon();
    rx = 1'b0;
    t0 = cyc;
    repeat (4) step();
    rx = 1'b1;
    repeat (30) step();
    check("glitch.tick_count", tick_q.size(), 1);
    check("glitch.tick_at", (tick_q.size() > 0) ? tick_q[0] : -1, t0 + 8);
    check("glitch.valid_count", valid_q.size(), 0);
    check("glitch.idle_rise", (rise_q.size() > 0) ? rise_q[0] : -1, t0 + 9);
    check("glitch.idle", {31'h0, idle}, 32'h1);
    check("glitch.rx_data_held", {24'h0, rx_data}, 32'h3C);

    // Abort: rx_enable dropped 36 cycles into a 0x55 frame
    step();
    clear_mon();
    rx = 1'b0;
    t0 = cyc;
    repeat (16) step();
    rx = 1'b1;
    repeat (16) step();
    rx = 1'b0;
    repeat (4) step();
    rx_enable = 1'b0;
    rx        = 1'b1;
    a         = cyc;
    repeat (30) step();
    check("abort.idle_rise", (rise_q.size() > 0) ? rise_q[0] : -1, a + 1);
    check("abort.tick_count", tick_q.size(), 2);
    check("abort.valid_count", valid_q.size(), 0);
    check("abort.rx_data_held", {24'h0, rx_data}, 32'h3C);
    rx_enable = 1'b1;
    repeat (4) step();

    // Reset in the middle of a 0x81 frame
    step();
    clear_mon();
    rx = 1'b0;
    repeat (16) step();
    rx = 1'b1;
    repeat (16) step();
    rx = 1'b0;
    repeat (10) step();
    rst_i = 1'b1;
    rx    = 1'b1;
    step();
    check_reset_outputs("mid_reset");
    rst_i = 1'b0;
    repeat (30) step();
    check("mid_reset.valid_count", valid_q.size(), 0);
    check("mid_reset.idle_after", {31'h0, idle}, 32'h1);

    // Clean 0x81 frame after the reset
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, t0);
    check_frame("post_reset_81", t0, 10, 10, 8'h81, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
